stream_mux_nto1: RTL and testbench

STREAM_MUX_NTO1 -- requirements
Module: stream_mux_nto1

---
 rtl/stream_mux_nto1.sv | 98 +++++++++
 tb/tb_stream_mux_nto1.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_nto1.sv
// N-to-1 valid/ready stream multiplexer: select-driven or round-robin
// arbitration feeding a single registered output stage.
module stream_mux_nto1 #(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SEL_W-1:0]     out_chan
);

  logic                 load_en_s;
  logic                 grant_vld_s;
  logic [SEL_W-1:0]     grant_idx_s;
  logic [WIDTH-1:0]     grant_data_s;
  logic [N-1:0]         in_ready_s;
  logic                 in_xfer_s;
  logic [WIDTH-1:0]     out_data_r;
  logic [SEL_W-1:0]     out_chan_r;
  logic                 out_valid_r;
  logic [SEL_W-1:0]     ptr_r;

  assign load_en_s = ~out_valid_r | out_ready;

  // Arbitration: pick the channel to serve on this cycle.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    if (mode == 1'b0) begin
      if ({1'b0, sel} < (SEL_W + 1)'(N)) begin
        grant_vld_s = in_valid[sel];
        grant_idx_s = sel;
      end else begin
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
      end
    end else begin
      // Walk the search order backwards so the earliest candidate after ptr wins.
      for (int i = N; i >= 1; i--) begin
        grant_vld_s = grant_vld_s | in_valid[(int'(ptr_r) + i) % N];
        grant_idx_s = in_valid[(int'(ptr_r) + i) % N] ? SEL_W'((int'(ptr_r) + i) % N)
                                                       : grant_idx_s;
      end
    end
  end

  // Data mux: only the granted lane is ever looked at, so X elsewhere stays out.
  always_comb begin
    grant_data_s = '0;
    for (int k = 0; k < N; k++) begin
      grant_data_s = (grant_idx_s == SEL_W'(k)) ? in_data[k*WIDTH +: WIDTH] : grant_data_s;
    end
  end

  // One-hot ready for the granted channel, suppressed while in reset.
  always_comb begin
    in_ready_s = '0;
    if (rst_n && grant_vld_s && load_en_s) begin
      in_ready_s[grant_idx_s] = 1'b1;
    end else begin
      in_ready_s = '0;
    end
  end

  assign in_xfer_s = grant_vld_s & load_en_s;

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_chan_r  <= '0;
      ptr_r       <= SEL_W'(N - 1);
    end else if (in_xfer_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= grant_data_s;
      out_chan_r  <= grant_idx_s;
      ptr_r       <= mode ? grant_idx_s : ptr_r;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_chan  = out_chan_r;

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Scoreboard bench for stream_mux_nto1: an N=4 instance for the main
// scenarios and an N=3 instance for the out-of-range select case.
module tb_stream_mux_nto1;

  localparam int WIDTH = 8;
  localparam int N     = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_chan;

  logic        mode3;
  logic [1:0]  sel3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic        out_valid3;
  logic        out_ready3;
  logic [1:0]  out_chan3;

  int          checks = 0;
  int          errors = 0;
  int          m_ptr;
  logic        m_ov;
  logic [9:0]  sb[$];

  stream_mux_nto1 #(.WIDTH(8), .N(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan)
  );

  stream_mux_nto1 #(.WIDTH(8), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3), .in_data(in_data3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_chan(out_chan3)
  );

  always #5 clk = ~clk;

  // Reference arbiter: -1 when nothing is grantable.
  function automatic int exp_grant();
    if (mode == 1'b0) return in_valid[sel] ? int'(sel) : -1;
    for (int i = 1; i <= N; i++) begin
      if (in_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int gg;
    gg = exp_grant();
    if (gg >= 0 && (!m_ov || out_ready)) return 4'b0001 << gg;
    return 4'b0000;
  endfunction

  // Advance the reference model across one rising edge.
  task automatic model_edge();
    int   gg;
    logic le;
    gg = exp_grant();
    le = !m_ov || out_ready;
    if (m_ov && out_ready && sb.size() > 0) void'(sb.pop_front());
    if (gg >= 0 && le) begin
      sb.push_back({2'(gg), in_data[gg*WIDTH +: WIDTH]});
      m_ov = 1'b1;
      if (mode) m_ptr = gg;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    in_valid = 4'b0000; in_valid3 = 3'b000;
    out_ready = 1'b0; out_ready3 = 1'b0;
    m_ov = 1'b0; m_ptr = N - 1; sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b1; sel = 2'd0; in_valid = 4'b1111; out_ready = 1'b1;
    in_data = $urandom;
    mode3 = 1'b0; sel3 = 2'd0; in_data3 = 24'h0; in_valid3 = 3'b000; out_ready3 = 1'b0;
    #3;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready: got %b exp 0000", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h exp 00", out_data); end
    checks++; if (out_chan !== 2'd0) begin errors++; $display("FAIL reset_out_chan: got %0d exp 0", out_chan); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_edge_valid: got %b exp 0", out_valid); end
    apply_reset();
  endtask

  task automatic test_mode0();
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      mode = 1'b0; out_ready = 1'b1;
      sel = (c < 2) ? 2'd2 : 2'($urandom_range(0, 3));
      in_valid = (c < 2) ? 4'b1111 : 4'($urandom);
      in_data = $urandom;
      if (c == 0) in_data[23:16] = 8'hA5;
      @(negedge clk);
      if (c == 0) begin
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL mode0_ready: got %b exp 0100", in_ready); end
      end
      if (c == 1) begin
        checks++; if ({out_valid, out_chan, out_data} !== {1'b1, 2'd2, 8'hA5})
          begin errors++; $display("FAIL mode0_word: got v%b ch%0d %h exp v1 ch2 a5", out_valid, out_chan, out_data); end
      end
      checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL mode0_sb_ready c%0d: got %b exp %b", c, in_ready, exp_ready()); end
      checks++; if (out_valid !== m_ov) begin errors++; $display("FAIL mode0_sb_valid c%0d: got %b exp %b", c, out_valid, m_ov); end
      if (m_ov && sb.size() > 0) begin
        checks++; if ({out_chan, out_data} !== sb[0]) begin errors++; $display("FAIL mode0_sb_word c%0d: got %h exp %h", c, {out_chan, out_data}, sb[0]); end
      end
      model_edge();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_round_robin();
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1; in_data = $urandom;
      @(negedge clk);
      if (c >= 1 && c <= 5) begin
        checks++; if (out_valid !== 1'b1 || out_chan !== 2'(exp_seq[c-1]))
          begin errors++; $display("FAIL rr_seq c%0d: got v%b ch%0d exp v1 ch%0d", c, out_valid, out_chan, exp_seq[c-1]); end
      end
      checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL rr_sb_ready c%0d: got %b exp %b", c, in_ready, exp_ready()); end
      if (m_ov && sb.size() > 0) begin
        checks++; if ({out_chan, out_data} !== sb[0]) begin errors++; $display("FAIL rr_sb_word c%0d: got %h exp %h", c, {out_chan, out_data}, sb[0]); end
      end
      model_edge();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      mode = 1'b1; in_valid = 4'b1111; in_data = $urandom;
      out_ready = (c == 0 || c >= 4);
      @(negedge clk);
      if (c >= 1 && c <= 3) begin
        checks++; if (in_ready !== 4'b0000 || out_chan !== 2'd0 || out_valid !== 1'b1)
          begin errors++; $display("FAIL bp_hold c%0d: got rdy %b ch%0d v%b exp rdy 0000 ch0 v1", c, in_ready, out_chan, out_valid); end
      end
      if (c == 5) begin
        checks++; if (out_chan !== 2'd1) begin errors++; $display("FAIL bp_release: got ch%0d exp ch1", out_chan); end
      end
      checks++; if (out_valid !== m_ov) begin errors++; $display("FAIL bp_sb_valid c%0d: got %b exp %b", c, out_valid, m_ov); end
      if (m_ov && sb.size() > 0) begin
        checks++; if ({out_chan, out_data} !== sb[0]) begin errors++; $display("FAIL bp_sb_word c%0d: got %h exp %h", c, {out_chan, out_data}, sb[0]); end
      end
      model_edge();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sparse();
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      mode = 1'b1; out_ready = 1'b1; in_data = $urandom;
      in_valid = (c == 0) ? 4'b1111 : (c == 3) ? 4'b0000 : 4'b1001;
      @(negedge clk);
      if (c == 1) begin
        checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL sparse_g3: got %b exp 1000", in_ready); end
      end
      if (c == 2) begin
        checks++; if (in_ready !== 4'b0001 || out_chan !== 2'd3) begin errors++; $display("FAIL sparse_g0: got %b ch%0d exp 0001 ch3", in_ready, out_chan); end
      end
      if (c == 3) begin
        checks++; if (out_chan !== 2'd0 || out_valid !== 1'b1) begin errors++; $display("FAIL sparse_out0: got ch%0d v%b exp ch0 v1", out_chan, out_valid); end
      end
      if (m_ov && sb.size() > 0) begin
        checks++; if ({out_chan, out_data} !== sb[0]) begin errors++; $display("FAIL sparse_sb_word c%0d: got %h exp %h", c, {out_chan, out_data}, sb[0]); end
      end
      model_edge();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int c = 0; c < 300; c++) begin
      mode = 1'($urandom); sel = 2'($urandom); in_valid = 4'($urandom);
      out_ready = ($urandom_range(0, 9) < 7); in_data = $urandom;
      @(negedge clk);
      checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL b2b_ready c%0d: got %b exp %b", c, in_ready, exp_ready()); end
      checks++; if (out_valid !== m_ov) begin errors++; $display("FAIL b2b_valid c%0d: got %b exp %b", c, out_valid, m_ov); end
      if (m_ov && sb.size() > 0) begin
        checks++; if ({out_chan, out_data} !== sb[0]) begin errors++; $display("FAIL b2b_word c%0d: got %h exp %h", c, {out_chan, out_data}, sb[0]); end
      end
      model_edge();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midstream();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0; in_data = $urandom;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b exp 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({out_valid, out_chan, out_data} !== 11'd0)
      begin errors++; $display("FAIL mid_reset_out: got v%b ch%0d %h exp all 0", out_valid, out_chan, out_data); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL mid_reset_ready: got %b exp 0000", in_ready); end
    apply_reset();
  endtask

  task automatic test_out_of_range();
    apply_reset();
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1; in_data3 = 24'h5C_3B_2A;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (in_ready3 !== 3'b000 || out_valid3 !== 1'b0)
        begin errors++; $display("FAIL oor_sel3 c%0d: got rdy %b v%b exp 000 v0", c, in_ready3, out_valid3); end
      @(posedge clk); #1;
    end
    sel3 = 2'd2;
    @(negedge clk);
    checks++; if (in_ready3 !== 3'b100) begin errors++; $display("FAIL oor_sel2_ready: got %b exp 100", in_ready3); end
    @(posedge clk); #1;
    in_valid3 = 3'b000;
    @(negedge clk);
    checks++; if ({out_valid3, out_chan3, out_data3} !== {1'b1, 2'd2, 8'h5C})
      begin errors++; $display("FAIL oor_sel2_word: got v%b ch%0d %h exp v1 ch2 5c", out_valid3, out_chan3, out_data3); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_round_robin();
    test_backpressure();
    test_sparse();
    test_back_to_back();
    test_reset_midstream();
    test_out_of_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
